segrw_addr_seq: RTL and testbench

//   Command-driven address/data sequencer upstream of the segment read/write datapath.

---
 rtl/segrw_addr_seq_if.sv | 43 ++++
 rtl/segrw_addr_seq.sv | 137 +++++++++++++
 tb/tb_segrw_addr_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/segrw_addr_seq_if.sv
// segrw_addr_seq_if: command, write-data and token streams of the segment address sequencer.
// Latency: none, wiring only.
// Backpressure: independent valid/ready pairs on the command, write-data and token channels.
interface segrw_addr_seq_if #(
  parameter int awidth = 7,
  parameter int dwidth = 7
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [awidth-1:0] cmd_base;
  logic [awidth-1:0] cmd_stride;
  logic [awidth:0]   cmd_len;
  logic              cmd_write;

  // write-data channel
  logic              wdata_valid;
  logic              wdata_ready;
  logic [dwidth-1:0] wdata;

  // token channel and status
  logic              out_valid;
  logic              out_ready;
  logic [awidth-1:0] addr_d;
  logic [dwidth-1:0] dataW_d;
  logic              write_d;
  logic              busy;
  logic              done;

  // command/wdata producer and token consumer
  modport master (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, cmd_write,
    output wdata_valid, wdata, out_ready,
    input  cmd_ready, wdata_ready, out_valid, addr_d, dataW_d, write_d, busy, done
  );

  // the sequencer itself
  modport slave (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, cmd_write,
    input  wdata_valid, wdata, out_ready,
    output cmd_ready, wdata_ready, out_valid, addr_d, dataW_d, write_d, busy, done
  );
endinterface

// File: rtl/segrw_addr_seq.sv
// segrw_addr_seq: turns one (base, stride, len, write) command into len address/data tokens, wrapping mod nelems.
// Latency: command accept -> first token valid one cycle later (writes also wait for wdata); 1 token/cycle.
// Backpressure: token register holds stable while out_valid && !out_ready; no wdata is consumed meanwhile.
module segrw_addr_seq #(
  parameter int nelems = 127,
  parameter int awidth = 7,
  parameter int dwidth = 7
) (
  input  logic            clock,
  input  logic            reset,
  segrw_addr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [awidth-1:0] addr;
    logic [dwidth-1:0] data;
    logic              write;
  } token_t;

  // Address arithmetic is done one bit wider so base+stride never overflows.
  localparam logic [awidth:0] nelems_w = (awidth + 1)'(nelems);
  localparam logic [awidth:0] one_w    = (awidth + 1)'(1);

  state_t            state;
  state_t            state_nxt;

  logic [awidth-1:0] stride;
  logic              write_mode;
  logic [awidth:0]   remaining;
  logic [awidth-1:0] cur_addr;
  token_t            token;
  logic              token_valid;

  logic              accept;
  logic              slot_free;
  logic              issue;
  logic              drain;
  logic [awidth:0]   sum;
  logic [awidth:0]   sum_wrapped;
  logic [awidth-1:0] next_addr;

  // Command fields may be up to 2^awidth-1; a single subtraction brings them into range.
  function automatic logic [awidth-1:0] reduce_once(input logic [awidth-1:0] v);
    logic [awidth:0] w;
    w = {1'b0, v};
    if (w >= nelems_w) begin
      w = w - nelems_w;
    end
    return w[awidth-1:0];
  endfunction

  // Handshake qualifiers and the wrapped next address.
  always_comb begin
    accept      = bus.cmd_valid && (state == IDLE);
    slot_free   = !token_valid || bus.out_ready;
    issue       = (state == RUN) && (remaining != '0) && slot_free
                  && (!write_mode || bus.wdata_valid);
    drain       = token_valid && bus.out_ready;
    sum         = {1'b0, cur_addr} + {1'b0, stride};
    sum_wrapped = (sum >= nelems_w) ? (sum - nelems_w) : sum;
    next_addr   = sum_wrapped[awidth-1:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: RUN ends only when the final token leaves the output register.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.cmd_len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if ((remaining == '0) && drain) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and ready outputs decoded from state; token fields come straight from the register.
  always_comb begin
    bus.cmd_ready   = (state == IDLE);
    bus.busy        = (state == RUN);
    bus.done        = (state == FIN);
    bus.wdata_ready = (state == RUN) && write_mode && (remaining != '0) && slot_free;
    bus.out_valid   = token_valid;
    bus.addr_d      = token.addr;
    bus.dataW_d     = token.data;
    bus.write_d     = token.write;
  end

  // Command latch, address walk and output token register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stride      <= '0;
      write_mode  <= 1'b0;
      remaining   <= '0;
      cur_addr    <= '0;
      token       <= '0;
      token_valid <= 1'b0;
    end else begin
      if (accept) begin
        stride     <= reduce_once(bus.cmd_stride);
        write_mode <= bus.cmd_write;
        remaining  <= bus.cmd_len;
        cur_addr   <= reduce_once(bus.cmd_base);
      end
      if (issue) begin
        token       <= '{addr: cur_addr, data: (write_mode ? bus.wdata : '0), write: write_mode};
        token_valid <= 1'b1;
        remaining   <= remaining - one_w;
        cur_addr    <= next_addr;
      end else if (drain) begin
        token_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segrw_addr_seq.sv
// tb_segrw_addr_seq: randomized command/wdata/backpressure stimulus against a modular-arithmetic token model.
// Latency: outputs sampled two time units after each rising edge; inputs driven one unit after it.
// Backpressure: out_ready is randomized and also forced low for fixed windows.
module tb_segrw_addr_seq;
  localparam int nelems = 127;
  localparam int awidth = 7;
  localparam int dwidth = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   first_hs;
  int   last_hs;

  segrw_addr_seq_if #(.awidth(awidth), .dwidth(dwidth)) bus();

  segrw_addr_seq #(.nelems(nelems), .awidth(awidth), .dwidth(dwidth)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Run one command to completion; tokens must be addr=(b+i*s) mod nelems and the i-th offered word.
  task automatic run_stream(input int base, input int stride, input int len, input bit wr,
                            input int ready_pct, input int wv_pct, input int bp_start,
                            input string name);
    int                b, s, tokens, widx, cycles;
    int                exp_addr[$];
    int                words[$];
    bit                held;
    bit                exp_wrdy;
    logic [awidth-1:0] h_addr;
    logic [dwidth-1:0] h_data;
    logic              h_write;
    logic [dwidth-1:0] ed;
    b = (base >= nelems) ? base - nelems : base;
    s = (stride >= nelems) ? stride - nelems : stride;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((b + i * s) % nelems);
      words.push_back(int'($urandom_range(0, (1 << dwidth) - 1)));
    end
    tokens = 0; widx = 0; cycles = 0; held = 0; first_hs = -1; last_hs = -1;

    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready_before_accept: got %b want 1", name, bus.cmd_ready);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = awidth'(base);
    bus.cmd_stride = awidth'(stride);
    bus.cmd_len    = (awidth + 1)'(len);
    bus.cmd_write  = wr;
    @(posedge clock); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = awidth'($urandom);
    bus.cmd_stride = awidth'($urandom);

    if (len == 0) begin
      #1;
      checks++;
      if ({bus.done, bus.busy, bus.out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL %s zero_len_done: got done=%b busy=%b out_valid=%b want 1 0 0",
                 name, bus.done, bus.busy, bus.out_valid);
      end
    end else begin
      while (tokens < len && cycles < 4000) begin
        bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        if (bp_start >= 0 && cycles >= bp_start && cycles < bp_start + 5) bus.out_ready = 1'b0;
        bus.wdata_valid = (wr ? (widx < len) : 1'b1) && ($urandom_range(0, 99) < wv_pct);
        bus.wdata = (wr && widx < len) ? dwidth'(words[widx]) : dwidth'($urandom);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_in_run cyc %0d: got busy=%b cmd_ready=%b want 1 0",
                   name, cycles, bus.busy, bus.cmd_ready);
        end
        exp_wrdy = wr && (widx < len) && (!bus.out_valid || bus.out_ready);
        checks++;
        if (bus.wdata_ready !== exp_wrdy) begin
          errors++;
          $display("FAIL %s wdata_ready cyc %0d: got %b want %b", name, cycles, bus.wdata_ready, exp_wrdy);
        end
        if (held) begin
          checks++;
          if ({bus.out_valid, bus.addr_d, bus.dataW_d, bus.write_d} !== {1'b1, h_addr, h_data, h_write}) begin
            errors++;
            $display("FAIL %s hold_stable cyc %0d: got v=%b addr=%0d data=%0h wr=%b want v=1 addr=%0d data=%0h wr=%b",
                     name, cycles, bus.out_valid, bus.addr_d, bus.dataW_d, bus.write_d, h_addr, h_data, h_write);
          end
        end
        held = bus.out_valid && !bus.out_ready;
        h_addr = bus.addr_d; h_data = bus.dataW_d; h_write = bus.write_d;
        if (bus.wdata_valid && bus.wdata_ready) widx++;
        if (bus.out_valid && bus.out_ready) begin
          ed = wr ? dwidth'(words[tokens]) : '0;
          checks++;
          if ({bus.addr_d, bus.dataW_d, bus.write_d} !== {awidth'(exp_addr[tokens]), ed, wr}) begin
            errors++;
            $display("FAIL %s token %0d: got addr=%0d data=%0h wr=%b want addr=%0d data=%0h wr=%b",
                     name, tokens, bus.addr_d, bus.dataW_d, bus.write_d, exp_addr[tokens], ed, wr);
          end
          if (first_hs < 0) first_hs = cycles;
          last_hs = cycles;
          tokens++;
        end
        @(posedge clock); #1;
        cycles++;
      end
      checks++;
      if (tokens != len) begin
        errors++; $display("FAIL %s token_count: got %0d want %0d (cycle budget)", name, tokens, len);
      end
      checks++;
      if (widx != (wr ? len : 0)) begin
        errors++; $display("FAIL %s words_consumed: got %0d want %0d", name, widx, wr ? len : 0);
      end
      bus.out_ready = 1'b0;
      bus.wdata_valid = 1'b0;
      #1;
      checks++;
      if ({bus.done, bus.busy, bus.out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL %s done_after_last: got done=%b busy=%b out_valid=%b want 1 0 0",
                 name, bus.done, bus.busy, bus.out_valid);
      end
    end
    @(posedge clock); #1;
    checks++;
    if ({bus.done, bus.cmd_ready, bus.out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL %s done_one_cycle: got done=%b cmd_ready=%b out_valid=%b want 0 1 0",
               name, bus.done, bus.cmd_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.out_valid, bus.busy, bus.done, bus.wdata_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_status: got rdy=%b v=%b busy=%b done=%b wrdy=%b want 1 0 0 0 0",
               bus.cmd_ready, bus.out_valid, bus.busy, bus.done, bus.wdata_ready);
    end
    checks++;
    if ({bus.addr_d, bus.dataW_d, bus.write_d} !== '0) begin
      errors++;
      $display("FAIL reset_token: got addr=%0d data=%0h wr=%b want 0 0 0", bus.addr_d, bus.dataW_d, bus.write_d);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_read_basic;
    run_stream(0, 1, 4, 1'b0, 100, 100, -1, "read_basic");
    checks++;
    if (first_hs != 1 || last_hs != 4) begin
      errors++; $display("FAIL read_basic_timing: got first=%0d last=%0d want 1 4", first_hs, last_hs);
    end
  endtask

  task automatic test_write_gaps;
    run_stream(10, 2, 3, 1'b1, 100, 40, -1, "write_gaps");
    run_stream(50, 9, 6, 1'b1, 70, 50, -1, "write_gaps2");
  endtask

  task automatic test_wrap;
    run_stream(125, 3, 3, 1'b0, 100, 100, -1, "wrap_125_3");
    run_stream(127, 127, 4, 1'b1, 100, 100, -1, "wrap_reduce");
    run_stream(126, 1, 3, 1'b0, 100, 100, -1, "wrap_126_1");
  endtask

  task automatic test_backpressure;
    run_stream(20, 5, 10, 1'b1, 100, 100, 3, "bp_write");
    run_stream(100, 40, 8, 1'b0, 100, 100, 2, "bp_read");
  endtask

  task automatic test_len_zero;
    run_stream(7, 3, 0, 1'b1, 100, 100, -1, "len_zero");
  endtask

  task automatic test_reset_mid;
    int tok = 0;
    int cyc = 0;
    bus.cmd_valid = 1'b1; bus.cmd_base = '0; bus.cmd_stride = 7'd1; bus.cmd_len = 8'd8; bus.cmd_write = 1'b0;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    while (tok < 2 && cyc < 50) begin
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) tok++;
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (tok != 2) begin
      errors++; $display("FAIL reset_mid_tokens: got %0d want 2", tok);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.cmd_ready, bus.done} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid_state: got v=%b busy=%b rdy=%b done=%b want 0 0 1 0",
               bus.out_valid, bus.busy, bus.cmd_ready, bus.done);
    end
    repeat (3) begin
      @(posedge clock); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_no_tokens: got out_valid=%b want 0", bus.out_valid);
      end
    end
    run_stream(3, 7, 5, 1'b1, 80, 80, -1, "after_reset");
  endtask

  task automatic test_back_to_back;
    run_stream(0, 126, 128, 1'b1, 90, 90, -1, "b2b_full_len");
    for (int k = 0; k < 10; k++) begin
      run_stream(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, "b2b_random");
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_stride = '0; bus.cmd_len = '0; bus.cmd_write = 1'b0;
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.out_ready = 1'b0;
    test_reset();
    test_read_basic();
    test_write_gaps();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
